// File: rtl/coriolis_fp_pkg.sv
// Shared FloPoCo / IEEE-754 single-precision definitions for the kernel output stages.
// FloPoCo FP32 word layout (34 bits): [33:32] exception, [31] sign, [30:23] exponent, [22:0] fraction.
package coriolis_fp_pkg;

    localparam int unsigned FPC_W  = 34;
    localparam int unsigned IEEE_W = 32;

    // Exception codes carried in the two FloPoCo MSBs
    localparam logic [1:0] FPC_EXN_ZERO = 2'b00;
    localparam logic [1:0] FPC_EXN_NORM = 2'b01;
    localparam logic [1:0] FPC_EXN_INF  = 2'b10;
    localparam logic [1:0] FPC_EXN_NAN  = 2'b11;

    localparam logic [IEEE_W-1:0] IEEE_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]        IEEE_EXP_MAX = 8'hFF;

    // Field positions within the FloPoCo word
    localparam int unsigned EXN_MSB  = 33;
    localparam int unsigned EXN_LSB  = 32;
    localparam int unsigned SIGN     = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned FRAC_MSB = 22;
    localparam int unsigned FRAC_LSB = 0;

endpackage

// File: rtl/coriolis_fpc2ieee.sv
// Combinational FloPoCo FP32 -> IEEE-754 binary32 converter.
// Ports:
//   fpc    in   FPC_W   FloPoCo word
//   res_c  out  IEEE_W  IEEE-754 word (combinational)
module coriolis_fpc2ieee
    import coriolis_fp_pkg::*;
(
    input  logic [FPC_W-1:0]  fpc,
    output logic [IEEE_W-1:0] res_c
);

    logic [1:0]  exn;
    logic        sgn;
    logic [7:0]  expo;
    logic [22:0] frac;

    assign exn  = fpc[EXN_MSB:EXN_LSB];
    assign sgn  = fpc[SIGN];
    assign expo = fpc[EXP_MSB:EXP_LSB];
    assign frac = fpc[FRAC_MSB:FRAC_LSB];

    // Map by exception code; NaN is canonicalised and loses its sign
    always_comb begin
        res_c = '0;
        case (exn)
            FPC_EXN_ZERO: res_c = {sgn, 31'b0};
            FPC_EXN_NORM: res_c = {sgn, expo, frac};
            FPC_EXN_INF:  res_c = {sgn, IEEE_EXP_MAX, 23'b0};
            FPC_EXN_NAN:  res_c = IEEE_QNAN;
            default:      res_c = IEEE_QNAN;
        endcase
    end

endmodule

// File: rtl/coriolis_ker0_ostage.sv
// Kernel-0 output stage: converts FloPoCo results to IEEE-754, buffers them in a
// first-word-fall-through FIFO and presents a ready/valid stream downstream.
// iready is a registered occupancy threshold leaving SKID slots for words still
// in flight in the leaf node when it sees iready drop.
// Optional statistics counters enabled with macro CORIOLIS_OSTAGE_STATS_EN.
// Ports:
//   clk        in   1     clock
//   rst        in   1     synchronous active-high reset
//   ivalid     in   1     upstream word valid
//   in1        in   INW   upstream FloPoCo word
//   iready     out  1     registered ready to upstream
//   ovalid     out  1     output word valid
//   out1       out  OUTW  IEEE-754 output word
//   oready     in   1     downstream ready
//   cnt_words  out  32    accepted-word counter (0 when stats disabled)
//   cnt_exc    out  16    non-normal accepted-word counter (0 when stats disabled)
module coriolis_ker0_ostage
    import coriolis_fp_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SKID  = 2,
    parameter int unsigned INW   = 34,
    parameter int unsigned OUTW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ivalid,
    input  logic [INW-1:0]  in1,
    output logic            iready,
    output logic            ovalid,
    output logic [OUTW-1:0] out1,
    input  logic            oready,
    output logic [31:0]     cnt_words,
    output logic [15:0]     cnt_exc
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned HI_MARK = DEPTH - SKID - 1;

    logic [OUTW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic [OUTW-1:0] conv_c;
    logic            rd_c;
    logic            wr_c;
    logic            drop_c;
    logic [CW-1:0]   count_rd_c;
    logic [CW-1:0]   count_next_c;
    logic [AW-1:0]   rd_ptr_next_c;

    coriolis_fpc2ieee u_conv (
        .fpc   (in1),
        .res_c (conv_c)
    );

    // Handshake decode; a read in the same cycle frees the slot for a write at full
    always_comb begin
        rd_c          = ovalid & oready;
        wr_c          = ivalid & ((count != CW'(DEPTH)) | rd_c);
        drop_c        = ivalid & ~wr_c;
        count_rd_c    = count - CW'(rd_c);
        count_next_c  = count_rd_c + CW'(wr_c);
        rd_ptr_next_c = rd_ptr + AW'(rd_c);
    end

    // Storage array, no reset needed: occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= conv_c;
        end
    end

    // Pointers, occupancy, sticky overflow and registered output stage.
    // The output view is built from entries stored before this edge, so a word
    // written now becomes visible one cycle later while a read immediately
    // exposes the next stored entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            iready   <= 1'b0;
            ovalid   <= 1'b0;
            out1     <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_c);
            rd_ptr <= rd_ptr_next_c;
            count  <= count_next_c;
            if (drop_c) begin
                overflow <= 1'b1;
            end
            iready <= (count_next_c <= CW'(HI_MARK));
            ovalid <= (count_rd_c != '0);
            if (count_rd_c != '0) begin
                out1 <= mem[rd_ptr_next_c];
            end
        end
    end

`ifdef CORIOLIS_OSTAGE_STATS_EN
    // Accepted-word (wrapping) and non-normal (saturating) counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_words <= '0;
            cnt_exc   <= '0;
        end else if (wr_c) begin
            cnt_words <= cnt_words + 32'd1;
            if ((in1[EXN_MSB:EXN_LSB] != FPC_EXN_NORM) && (cnt_exc != 16'hFFFF)) begin
                cnt_exc <= cnt_exc + 16'd1;
            end
        end
    end
`else
    assign cnt_words = '0;
    assign cnt_exc   = '0;
`endif

endmodule

// File: tb/tb_coriolis_ker0_ostage.sv
// Self-checking bench for coriolis_ker0_ostage: directed phases plus randomized
// traffic, compared every cycle against a queue-based behavioural model.
module tb_coriolis_ker0_ostage;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SKID  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivalid;
    logic [33:0] in1;
    logic        iready;
    logic        ovalid;
    logic [31:0] out1;
    logic        oready;
    logic [31:0] cnt_words;
    logic [15:0] cnt_exc;

    int checks = 0;
    int errors = 0;

    coriolis_ker0_ostage #(
        .DEPTH (DEPTH),
        .SKID  (SKID),
        .INW   (34),
        .OUTW  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ivalid    (ivalid),
        .in1       (in1),
        .iready    (iready),
        .ovalid    (ovalid),
        .out1      (out1),
        .oready    (oready),
        .cnt_words (cnt_words),
        .cnt_exc   (cnt_exc)
    );

    always #5 clk = ~clk;

    // Reference conversion straight from the exception-code table
    function automatic logic [31:0] ref_conv(logic [33:0] w);
        case (w[33:32])
            2'b00:   return {w[31], 31'b0};
            2'b01:   return w[31:0];
            2'b10:   return {w[31], 8'hFF, 23'b0};
            default: return 32'h7FC0_0000;
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words tagged with the edge they were written on.
    // A word is visible at the head only from the edge after its write.
    typedef struct {
        logic [31:0] data;
        int          wcyc;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    bit          m_ov = 0;
    logic [31:0] m_out = '0;
    bit          m_ir = 0;
    bit          m_ovf = 0;
    logic [31:0] m_words = '0;
    logic [15:0] m_exc = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            m_ov    = 0;
            m_out   = '0;
            m_ir    = 0;
            m_ovf   = 0;
            m_words = '0;
            m_exc   = '0;
        end else begin
            if (m_ov && oready) void'(q.pop_front());
            if (ivalid) begin
                if (q.size() < DEPTH) begin
                    q.push_back('{data: ref_conv(in1), wcyc: cyc});
                    m_words++;
                    if (in1[33:32] != 2'b01 && m_exc != 16'hFFFF) m_exc++;
                end else begin
                    m_ovf = 1;
                end
            end
            m_ov = 0;
            if (q.size() > 0) begin
                if (q[0].wcyc < cyc) m_ov = 1;
            end
            if (m_ov) m_out = q[0].data;
            m_ir = (q.size() <= DEPTH - SKID - 1);
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("iready", 64'(iready), 64'(m_ir));
        chk("ovalid", 64'(ovalid), 64'(m_ov));
        if (m_ov) chk("out1", 64'(out1), 64'(m_out));
        chk("overflow", 64'(dut.overflow), 64'(m_ovf));
        chk("count", 64'(dut.count), 64'(q.size()));
`ifdef CORIOLIS_OSTAGE_STATS_EN
        chk("cnt_words", 64'(cnt_words), 64'(m_words));
        chk("cnt_exc", 64'(cnt_exc), 64'(m_exc));
`else
        chk("cnt_words", 64'(cnt_words), 64'(0));
        chk("cnt_exc", 64'(cnt_exc), 64'(0));
`endif
    end

    // Apply inputs at a negedge and return at the next negedge (one active edge later)
    task automatic drive(bit v, logic [33:0] d, bit rdy);
        ivalid = v;
        in1    = d;
        oready = rdy;
        @(negedge clk);
    endtask

    function automatic logic [33:0] rnd_word();
        logic [1:0] e;
        e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
        return {e, 32'($urandom)};
    endfunction

    logic [33:0] sweep_in [4];
    logic [31:0] sweep_out [4];

    initial begin
        sweep_in[0]  = 34'h1_3F80_2058;
        sweep_in[1]  = 34'h0_8000_0000;
        sweep_in[2]  = 34'h2_8000_0000;
        sweep_in[3]  = 34'h3_1234_5678;
        sweep_out[0] = 32'h3F80_2058;
        sweep_out[1] = 32'h8000_0000;
        sweep_out[2] = 32'hFF80_0000;
        sweep_out[3] = 32'h7FC0_0000;

        rst    = 1'b1;
        ivalid = 1'b0;
        in1    = '0;
        oready = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_iready", 64'(iready), 64'(0));
            chk("rst_ovalid", 64'(ovalid), 64'(0));
            chk("rst_out1", 64'(out1), 64'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        chk("release_iready", 64'(iready), 64'(1));

        // Conversion sweep with one-cycle write-to-output latency
        drive(1'b1, sweep_in[0], 1'b1);
        chk("lat_ovalid0", 64'(ovalid), 64'(0));
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) drive(1'b1, sweep_in[k], 1'b1);
            else       drive(1'b0, '0, 1'b1);
            chk("sweep_ovalid", 64'(ovalid), 64'(1));
            chk("sweep_out1", 64'(out1), 64'(sweep_out[k-1]));
        end
        drive(1'b0, '0, 1'b1);
        chk("sweep_empty", 64'(ovalid), 64'(0));
        drive(1'b0, '0, 1'b1);

        // Fill with oready low; threshold and skid writes
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, rnd_word(), 1'b0);
            chk("fill_iready", 64'(iready), 64'((i <= 13) ? 1 : 0));
        end
        chk("fill_count15", 64'(dut.count), 64'(15));
        chk("fill_model15", 64'(q.size()), 64'(15));
        chk("fill_noovf", 64'(dut.overflow), 64'(0));
        drive(1'b1, rnd_word(), 1'b0);
        chk("full_count", 64'(dut.count), 64'(16));

        // Simultaneous read and write at full
        drive(1'b1, rnd_word(), 1'b1);
        chk("simul_count", 64'(dut.count), 64'(16));
        chk("simul_noovf", 64'(dut.overflow), 64'(0));

        // Drain from full
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, '0, 1'b1);
            if (i == 3) chk("drain_iready", 64'(iready), 64'(1));
        end
        chk("drained_ovalid", 64'(ovalid), 64'(0));

        // Overflow: one write beyond full is dropped and flagged until reset
        for (int i = 0; i < 17; i++) drive(1'b1, rnd_word(), 1'b0);
        chk("ovf_flag", 64'(dut.overflow), 64'(1));
        chk("ovf_count", 64'(dut.count), 64'(16));
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("ovf_cleared", 64'(dut.overflow), 64'(0));
        chk("rst_mid_ovalid", 64'(ovalid), 64'(0));
        drive(1'b0, '0, 1'b0);

        // Statistics: ten writes, three non-normal
        for (int i = 0; i < 10; i++) begin
            logic [33:0] w;
            w = {2'b01, 32'($urandom)};
            if (i == 2) w = 34'h0_0000_0000;
            if (i == 5) w = 34'h2_0000_0000;
            if (i == 8) w = 34'h3_0000_0001;
            drive(1'b1, w, 1'b1);
        end
        drive(1'b0, '0, 1'b1);
`ifdef CORIOLIS_OSTAGE_STATS_EN
        chk("stats_words", 64'(cnt_words), 64'(10));
        chk("stats_exc", 64'(cnt_exc), 64'(3));
`else
        chk("stats_words_off", 64'(cnt_words), 64'(0));
        chk("stats_exc_off", 64'(cnt_exc), 64'(0));
`endif
        rst = 1'b1;
        drive(1'b0, '0, 1'b1);
        rst = 1'b0;
        chk("stats_rst_words", 64'(cnt_words), 64'(0));
        chk("stats_rst_exc", 64'(cnt_exc), 64'(0));

        // Randomized traffic mostly honouring iready, with rare mid-stream resets
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit r;
            v = iready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) == 0);
            drive(v, rnd_word(), r);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b1);
        chk("final_empty", 64'(ovalid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
